// File: rtl/crossbar_slave_mem.sv
// crossbar_slave_mem: word-addressed SRAM target with programmable wait states and one-cycle ack
module crossbar_slave_mem #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        cmd,
  input  logic [30:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t state, next_state;
  logic [3:0] cnt;
  logic cmd_q;
  logic [30:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] mem [2**DEPTH_LOG2];
  logic acc_cmd, enter_ack, in_range;
  logic [30:0] acc_addr;
  logic [31:0] acc_wdata;
  // with zero wait states the access happens on the accepting edge, so use live inputs there
  always_comb begin
    next_state = (state == IDLE) ? (req ? ((WAIT_CYCLES == 0) ? ACK : WAIT) : IDLE) :
                 (state == WAIT) ? ((cnt == 4'd0) ? ACK : WAIT) : IDLE;
    acc_cmd    = (state == IDLE) ? cmd : cmd_q;
    acc_addr   = (state == IDLE) ? addr : addr_q;
    acc_wdata  = (state == IDLE) ? wdata : wdata_q;
    enter_ack  = (next_state == ACK) && !reset;
    in_range   = (acc_addr >> DEPTH_LOG2) == 31'd0;
  end
  assign busy = (state != IDLE);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      cmd_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack     <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= next_state;
      ack   <= enter_ack;
      if (state == IDLE && req) begin
        cmd_q   <= cmd;
        addr_q  <= addr;
        wdata_q <= wdata;
        cnt     <= 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_ack && !acc_cmd)
        rdata <= in_range ? mem[acc_addr[DEPTH_LOG2-1:0]] : 32'h0;
    end
  end
  // storage is deliberately outside the reset domain
  always_ff @(posedge clock) begin
    if (enter_ack && acc_cmd && in_range)
      mem[acc_addr[DEPTH_LOG2-1:0]] <= acc_wdata;
  end
endmodule

// File: tb/tb_crossbar_slave_mem.sv
// tb_crossbar_slave_mem: directed checks on three instances with 0, 2 and 3 wait states
module tb_crossbar_slave_mem;
  logic clock = 1'b0;
  logic rst [3];
  logic req [3];
  logic cmd [3];
  logic [30:0] addr [3];
  logic [31:0] wdata [3];
  logic ack [3];
  logic [31:0] rdata [3];
  logic busy [3];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  localparam int WC [3] = '{0, 2, 3};

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  crossbar_slave_mem #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_w0 (
    .clock(clock), .reset(rst[0]), .req(req[0]), .cmd(cmd[0]), .addr(addr[0]),
    .wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]), .busy(busy[0]));
  crossbar_slave_mem #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) u_w2 (
    .clock(clock), .reset(rst[1]), .req(req[1]), .cmd(cmd[1]), .addr(addr[1]),
    .wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]), .busy(busy[1]));
  crossbar_slave_mem #(.DEPTH_LOG2(8), .WAIT_CYCLES(3)) u_w3 (
    .clock(clock), .reset(rst[2]), .req(req[2]), .cmd(cmd[2]), .addr(addr[2]),
    .wdata(wdata[2]), .ack(ack[2]), .rdata(rdata[2]), .busy(busy[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // req held through the ack cycle and dropped after the ack-exit edge, as the crossbar does
  task automatic txn(input int i, input logic c, input logic [30:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output int lat, output int bz, output int ack_cyc);
    @(negedge clock);
    req[i] = 1'b1; cmd[i] = c; addr[i] = a; wdata[i] = d;
    lat = 0; bz = 0;
    do begin
      @(posedge clock); #1;
      lat++;
      if (busy[i]) bz++;
    end while (!ack[i] && lat < 20);
    if (!ack[i]) chk("ack_timeout", 32'd0, 32'd1);
    rd = rdata[i];
    ack_cyc = cyc;
    @(posedge clock); #1;
    req[i] = 1'b0;
    chk("ack_single_pulse", 32'(ack[i]), 32'd0);
    chk("busy_after_ack", 32'(busy[i]), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int lat, bz, c1, c2;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; cmd[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ack", 32'(ack[i]), 32'd0);
      chk("rst_rdata", rdata[i], 32'h0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
    end
    // zero wait states
    txn(0, 1'b1, 31'hA, 32'h0000000A, rd, lat, bz, c1);
    chk("w0_wr_lat", 32'(lat), 32'd1);
    txn(0, 1'b0, 31'hA, 32'h0, rd, lat, bz, c1);
    chk("w0_rd_lat", 32'(lat), 32'd1);
    chk("w0_rd_data", rd, 32'h0000000A);
    txn(0, 1'b1, 31'hB, 32'h0000000B, rd, lat, bz, c1);
    txn(0, 1'b0, 31'hB, 32'h0, rd, lat, bz, c1);
    chk("w0_tail_rd", rd, 32'h0000000B);
    // out of range
    txn(0, 1'b1, 31'h0, 32'h00000055, rd, lat, bz, c1);
    txn(0, 1'b1, 31'h100, 32'hFFFFFFFF, rd, lat, bz, c1);
    chk("oor_wr_lat", 32'(lat), 32'd1);
    chk("rdata_hold_on_wr", rdata[0], 32'h0000000B);
    txn(0, 1'b0, 31'h100, 32'h0, rd, lat, bz, c1);
    chk("oor_rd_lat", 32'(lat), 32'd1);
    chk("oor_rd_data", rd, 32'h0);
    txn(0, 1'b0, 31'h0, 32'h0, rd, lat, bz, c1);
    chk("addr0_intact", rd, 32'h00000055);
    // back-to-back reads, zero wait
    txn(0, 1'b0, 31'hA, 32'h0, rd, lat, bz, c1);
    chk("b2b0_rd_a", rd, 32'h0000000A);
    txn(0, 1'b0, 31'hB, 32'h0, rd, lat, bz, c2);
    chk("b2b0_rd_b", rd, 32'h0000000B);
    chk("b2b0_gap", 32'(c2 - c1), 32'(WC[0] + 2));
    // two wait states
    txn(1, 1'b1, 31'h5, 32'h12345678, rd, lat, bz, c1);
    chk("w2_wr_lat", 32'(lat), 32'd3);
    chk("w2_wr_busy", 32'(bz), 32'd3);
    txn(1, 1'b0, 31'h5, 32'h0, rd, lat, bz, c1);
    chk("w2_rd_lat", 32'(lat), 32'd3);
    chk("w2_rd_busy", 32'(bz), 32'd3);
    chk("w2_rd_data", rd, 32'h12345678);
    txn(1, 1'b1, 31'hA, 32'h0000AAAA, rd, lat, bz, c1);
    txn(1, 1'b1, 31'hB, 32'h0000BBBB, rd, lat, bz, c1);
    txn(1, 1'b0, 31'hA, 32'h0, rd, lat, bz, c1);
    chk("b2b2_rd_a", rd, 32'h0000AAAA);
    txn(1, 1'b0, 31'hB, 32'h0, rd, lat, bz, c2);
    chk("b2b2_rd_b", rd, 32'h0000BBBB);
    chk("b2b2_gap", 32'(c2 - c1), 32'(WC[1] + 2));
    // three wait states, reset mid-transaction
    txn(2, 1'b1, 31'h3, 32'h00001111, rd, lat, bz, c1);
    chk("w3_wr_lat", 32'(lat), 32'd4);
    txn(2, 1'b0, 31'h3, 32'h0, rd, lat, bz, c1);
    chk("w3_rd_data", rd, 32'h00001111);
    @(negedge clock);
    req[2] = 1'b1; cmd[2] = 1'b1; addr[2] = 31'h3; wdata[2] = 32'h0000CAFE;
    @(posedge clock); #1;
    chk("w3_busy_in_wait", 32'(busy[2]), 32'd1);
    #2 rst[2] = 1'b1;
    #1;
    chk("rst_busy_drop", 32'(busy[2]), 32'd0);
    chk("rst_rdata_clear", rdata[2], 32'h0);
    req[2] = 1'b0;
    c2 = 0;
    repeat (5) begin
      @(posedge clock); #1;
      if (ack[2]) c2++;
    end
    @(negedge clock);
    rst[2] = 1'b0;
    repeat (5) begin
      @(posedge clock); #1;
      if (ack[2]) c2++;
    end
    chk("rst_no_ack", 32'(c2), 32'd0);
    txn(2, 1'b0, 31'h3, 32'h0, rd, lat, bz, c1);
    chk("rst_post_lat", 32'(lat), 32'd4);
    chk("rst_no_commit", rd, 32'h00001111);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
